sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester (IF) and the data requester (EX stage `data_sram_*`).
- Performs fixed-priority arbitration, data over inst, with an anti-starvation override for inst.
- Holds the grant stable until the request is accepted.
- Tracks outstanding transactions in order and routes each `mem_data_ok`/`mem_rdata` back to its originator.
- Sits between the pipeline stages and the AXI bridge / cache.

Parameters:
- MAX_OUTSTANDING, 4, depth of the in-order source-tag FIFO (power of two, 2..16).
- STARVE_LIMIT, 3, consecutive data grants accepted while `inst_req` is pending before inst is forced to win (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  IF request
- inst_wr  in  1  IF write flag (normally 0)
- inst_size  in  2  00=byte, 01=half, 10=word
- inst_wstrb  in  4  IF byte strobes
- inst_addr  in  32  IF address
- inst_wdata  in  32  IF write data
- inst_addr_ok  out  1  IF request accepted
- inst_data_ok  out  1  IF response
- inst_rdata  out  32  IF read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  EX request, same meaning as inst_*
- data_addr_ok  out  1  EX request accepted
- data_data_ok  out  1  EX response
- data_rdata  out  32  EX read data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write flag
- mem_size  out  2  downstream size
- mem_wstrb  out  4  downstream strobes
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_addr_ok  in  1  downstream accept
- mem_data_ok  in  1  downstream response
- mem_rdata  in  32  downstream read data
- outstanding  out  log2(MAX_OUTSTANDING)+1  current in-flight count
- protocol_err  out  1  sticky error flag

Behaviour:
- **Reset (async, active-high):**
  - `state`=IDLE, FIFO empty, `outstanding`=0, `starve_cnt`=0, `protocol_err`=0.
  - `mem_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok` are all 0 while reset is asserted.
  - `inst_rdata`/`data_rdata` are 0 while reset is asserted.
- **Accepted:** the cycle `mem_req & mem_addr_ok` is high. In that cycle the granted source's `addr_ok` = `mem_addr_ok`; the other source's `addr_ok` = 0.
- **FSM, two states:**
  - IDLE: select a source combinationally.
    - Data wins if `data_req` and not (`inst_req` & `starve_cnt`==STARVE_LIMIT).
    - Otherwise inst wins if `inst_req`.
    - If selected and not accepted in that cycle, latch the selection into `grant_src` and go to HOLD.
    - If accepted in that cycle, stay in IDLE.
  - HOLD: the mux is forced to `grant_src` regardless of the other requester.
    - Return to IDLE on accept.
    - Also return to IDLE when the granted source's req drops (withdrawn request); `mem_req` follows the dropped req the same cycle.
- **Downstream mux:** `mem_req` = selected req & (`outstanding` != MAX_OUTSTANDING). `mem_wr`/`mem_size`/`mem_wstrb`/`mem_addr`/`mem_wdata` come from the selected source; they are 0 when nothing is selected.
- **Full FIFO:** when `outstanding`==MAX_OUTSTANDING, `mem_req`=0. A pop in the same cycle does not unblock the request; the request retries next cycle.
- **Tag FIFO:**
  - Push the source tag (0=inst, 1=data) on accept; pop on `mem_data_ok`.
  - Push and pop in the same cycle are both performed; `outstanding` is unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
- **Response routing:** combinational, zero added latency, by head tag.
  - `inst_data_ok` = `mem_data_ok` & head==0; `data_data_ok` = `mem_data_ok` & head==1.
  - Both `rdata` outputs carry `mem_rdata`; each is qualified only by its own `data_ok`.
  - Write responses are routed the same way.
- **starve_cnt:**
  - Increments (saturating at STARVE_LIMIT) on each accepted data request while `inst_req`=1.
  - Clears on an accepted inst request, or on any cycle with `inst_req`=0.
- **protocol_err:** set, and held until reset, on `mem_data_ok` with an empty FIFO. No pop occurs and neither `data_ok` is asserted.
- **Responses during reset:** any response arriving while reset is asserted is dropped.

Test Plan:
- Single read: `data_req`=1, `data_addr`=0x1C000100, `data_size`=2'b10, `mem_addr_ok` at cycle 0 → `mem_addr`=0x1C000100 and `data_addr_ok`=1 at cycle 0; `outstanding`=1. `mem_data_ok` with `mem_rdata`=0xDEADBEEF at cycle 3 → `data_data_ok`=1 and `data_rdata`=0xDEADBEEF at cycle 3; `inst_data_ok`=0; `outstanding`=0.
- Hold: `inst_req`=1 with `mem_addr_ok`=0 for 2 cycles, then `data_req` rises → `mem_addr` stays at `inst_addr` until accept; `data_addr_ok`=0 throughout.
- Starvation: both requesters continuously active, `mem_addr_ok`=1 and `mem_data_ok` pulsed each cycle, STARVE_LIMIT=3 → grant sequence D,D,D,I,D,D,D,I.
- Full: 4 accepted requests and no `data_ok` → 5th request sees `mem_req`=0 and `outstanding`=4. One `mem_data_ok` arrives → `mem_req`=1 the next cycle.
- Ordering: accept I,D,I; return 3 `data_ok` pulses with rdata 1,2,3 → `inst_data_ok` on 1 and 3, `data_data_ok` on 2.
- Error/reset: `mem_data_ok` with empty FIFO → `protocol_err`=1 and held. Assert reset mid-HOLD with 2 outstanding → `state` IDLE, `outstanding`=0, `protocol_err`=0 immediately (asynchronous).

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like port between the instruction-fetch and data requesters.
// Data has fixed priority over inst, with a starvation override for inst. The grant
// is held until the request is accepted. Responses are routed back in order using a
// small source-tag FIFO.
module sram_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  // IF requester
  input  logic                               inst_req,
  input  logic                               inst_wr,
  input  logic [1:0]                         inst_size,
  input  logic [3:0]                         inst_wstrb,
  input  logic [31:0]                        inst_addr,
  input  logic [31:0]                        inst_wdata,
  output logic                               inst_addr_ok,
  output logic                               inst_data_ok,
  output logic [31:0]                        inst_rdata,
  // EX requester
  input  logic                               data_req,
  input  logic                               data_wr,
  input  logic [1:0]                         data_size,
  input  logic [3:0]                         data_wstrb,
  input  logic [31:0]                        data_addr,
  input  logic [31:0]                        data_wdata,
  output logic                               data_addr_ok,
  output logic                               data_data_ok,
  output logic [31:0]                        data_rdata,
  // Downstream port
  output logic                               mem_req,
  output logic                               mem_wr,
  output logic [1:0]                         mem_size,
  output logic [3:0]                         mem_wstrb,
  output logic [31:0]                        mem_addr,
  output logic [31:0]                        mem_wdata,
  input  logic                               mem_addr_ok,
  input  logic                               mem_data_ok,
  input  logic [31:0]                        mem_rdata,
  // Status
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               protocol_err
);

  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] MaxCnt    = CntW'(MAX_OUTSTANDING);
  localparam logic [3:0]      StarveMax = 4'(STARVE_LIMIT);

  // Source tag encoding: 0 = inst, 1 = data
  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e                     state_q, state_d;
  logic                       grant_src_q, grant_src_d;
  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [3:0]                 starve_q, starve_d;
  logic                       err_q;

  logic sel_valid, sel_src;
  logic full, accept, push, pop, head;

  // Source selection: arbitrate in idle, lock to the latched grant in hold
  always_comb begin
    sel_valid = 1'b0;
    sel_src   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (data_req && !(inst_req && (starve_q == StarveMax))) begin
          sel_valid = 1'b1;
          sel_src   = 1'b1;
        end else if (inst_req) begin
          sel_valid = 1'b1;
          sel_src   = 1'b0;
        end
      end
      StHold: begin
        sel_src   = grant_src_q;
        sel_valid = grant_src_q ? data_req : inst_req;
      end
      default: ;
    endcase
  end

  assign full   = (cnt_q == MaxCnt);
  // A pop in the same cycle does not free a slot for this cycle's request
  assign mem_req = sel_valid & ~full & ~reset;
  assign accept  = mem_req & mem_addr_ok;
  assign push    = accept;
  assign pop     = mem_data_ok & (cnt_q != '0) & ~reset;
  assign head    = tag_q[rd_ptr_q];

  // Downstream payload mux; zero when nothing is selected
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'b00;
    mem_wstrb = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (sel_valid) begin
      if (sel_src) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end
  end

  // Request acceptance and in-order response routing by head tag
  always_comb begin
    inst_addr_ok = accept & ~sel_src;
    data_addr_ok = accept & sel_src;
    inst_data_ok = pop & ~head;
    data_data_ok = pop & head;
    inst_rdata   = reset ? 32'h0 : mem_rdata;
    data_rdata   = reset ? 32'h0 : mem_rdata;
  end

  // FSM next state: latch an unaccepted grant, release on accept or withdrawal
  always_comb begin
    state_d     = state_q;
    grant_src_d = grant_src_q;
    unique case (state_q)
      StIdle: begin
        if (sel_valid && !accept) begin
          state_d     = StHold;
          grant_src_d = sel_src;
        end
      end
      StHold: begin
        if (accept || !sel_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outstanding count and starvation counter next state
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    starve_d = starve_q;
    if (!inst_req) begin
      starve_d = 4'h0;
    end else if (accept && !sel_src) begin
      starve_d = 4'h0;
    end else if (accept && sel_src && (starve_q != StarveMax)) begin
      starve_d = starve_q + 4'h1;
    end
  end

  // FSM and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_src_q <= 1'b0;
      cnt_q       <= '0;
      starve_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      grant_src_q <= grant_src_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
    end
  end

  // Tag FIFO storage and pointers; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= sel_src;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Sticky flag for a response with nothing in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (mem_data_ok && (cnt_q == '0)) begin
      err_q <= 1'b1;
    end
  end

  assign outstanding  = cnt_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter. Expected responses are queued as stimulus is
// issued and a negedge monitor pops and compares them whenever a data_ok appears.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  outstanding;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  // {src, rdata}: src 0 = inst, 1 = data
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT   (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_wr     (inst_wr),
    .inst_size   (inst_size),
    .inst_wstrb  (inst_wstrb),
    .inst_addr   (inst_addr),
    .inst_wdata  (inst_wdata),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .outstanding (outstanding),
    .protocol_err(protocol_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor
  always @(negedge clk) begin
    logic [32:0] e;
    logic [31:0] got;
    if (inst_data_ok || data_data_ok) begin
      checks++;
      got = data_data_ok ? data_rdata : inst_rdata;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got src %0d rdata 0x%08h expected no response",
                 data_data_ok, got);
      end else begin
        e = exp_q.pop_front();
        if ((inst_data_ok && data_data_ok) || (data_data_ok != e[32]) || (got !== e[31:0])) begin
          errors++;
          $display("FAIL resp_route: got inst_ok %0d data_ok %0d rdata 0x%08h expected src %0d rdata 0x%08h",
                   inst_data_ok, data_data_ok, got, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_inst;
    logic       prev_src;

    // Reset with live inputs: everything outgoing must stay quiet
    reset = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'b10; inst_wstrb = 4'h0;
    inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_wstrb = 4'h0;
    data_addr = 32'h1C000000; data_wdata = 32'h0;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_protocol_err", protocol_err, 0);
    tick();
    reset = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    tick();

    // Single read
    data_req = 1'b1; data_addr = 32'h1C000100; data_size = 2'b10; mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("rd_mem_req", mem_req, 1);
    chk("rd_mem_addr", mem_addr, 32'h1C000100);
    chk("rd_mem_size", mem_size, 2);
    chk("rd_data_addr_ok", data_addr_ok, 1);
    chk("rd_inst_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    @(negedge clk);
    chk("rd_outstanding1", outstanding, 1);
    tick();
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'hDEADBEEF;
    exp_q.push_back({1'b1, 32'hDEADBEEF});
    @(negedge clk);
    chk("rd_data_data_ok", data_data_ok, 1);
    chk("rd_inst_data_ok", inst_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("rd_outstanding0", outstanding, 0);
    tick();

    // Hold: inst grant is locked against a later data request
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    @(negedge clk);
    chk("hold_addr_c0", mem_addr, 32'hBFC00000);
    tick();
    @(negedge clk);
    chk("hold_addr_c1", mem_addr, 32'hBFC00000);
    tick();
    data_req = 1'b1; data_addr = 32'h1C000200;
    @(negedge clk);
    chk("hold_addr_c2", mem_addr, 32'hBFC00000);
    chk("hold_data_addr_ok_c2", data_addr_ok, 0);
    tick();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("hold_addr_acc", mem_addr, 32'hBFC00000);
    chk("hold_inst_addr_ok", inst_addr_ok, 1);
    chk("hold_data_addr_ok_acc", data_addr_ok, 0);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    @(negedge clk);
    chk("hold_then_data_addr", mem_addr, 32'h1C000200);
    tick();
    // Withdrawn request while held
    data_req = 1'b0;
    @(negedge clk);
    chk("withdraw_mem_req", mem_req, 0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h11111111;
    exp_q.push_back({1'b0, 32'h11111111});
    @(negedge clk);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("hold_outstanding0", outstanding, 0);
    tick();

    // Starvation: D,D,D,I,D,D,D,I (bit k set = inst granted in cycle k)
    exp_inst = 8'b1000_1000;
    prev_src = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mem_data_ok = (k > 0);
      mem_rdata   = 32'(k);
      if (k > 0) exp_q.push_back({prev_src, 32'(k)});
      @(negedge clk);
      chk($sformatf("starve_data_ok_c%0d", k), data_addr_ok, !exp_inst[k]);
      chk($sformatf("starve_inst_ok_c%0d", k), inst_addr_ok, exp_inst[k]);
      prev_src = !exp_inst[k];
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h8;
    exp_q.push_back({prev_src, 32'h8});
    @(negedge clk);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("starve_outstanding0", outstanding, 0);
    tick();

    // Full FIFO
    data_req = 1'b1; mem_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_addr = 32'h1C001000 + 32'(4 * k);
      @(negedge clk);
      chk($sformatf("full_accept_c%0d", k), data_addr_ok, 1);
      tick();
    end
    data_addr = 32'h1C002000;
    @(negedge clk);
    chk("full_outstanding4", outstanding, 4);
    chk("full_mem_req0", mem_req, 0);
    chk("full_data_addr_ok0", data_addr_ok, 0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'hA0;
    exp_q.push_back({1'b1, 32'hA0});
    @(negedge clk);
    chk("full_pop_no_unblock", mem_req, 0);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("full_retry_mem_req", mem_req, 1);
    chk("full_outstanding3", outstanding, 3);
    chk("full_retry_addr_ok", data_addr_ok, 1);
    chk("full_retry_addr", mem_addr, 32'h1C002000);
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_data_ok = 1'b1; mem_rdata = 32'hB0 + 32'(k);
      exp_q.push_back({1'b1, 32'hB0 + 32'(k)});
      @(negedge clk);
      tick();
    end
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("full_drained", outstanding, 0);
    tick();

    // Ordering: accept I, D, I then return 1, 2, 3
    mem_addr_ok = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC00010;
    @(negedge clk);
    chk("ord_acc_i0", inst_addr_ok, 1);
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h1C000400;
    @(negedge clk);
    chk("ord_acc_d1", data_addr_ok, 1);
    tick();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC00014;
    @(negedge clk);
    chk("ord_acc_i2", inst_addr_ok, 1);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      mem_data_ok = 1'b1; mem_rdata = 32'(k);
      exp_q.push_back({(k == 2) ? 1'b1 : 1'b0, 32'(k)});
      @(negedge clk);
      chk($sformatf("ord_inst_ok_%0d", k), inst_data_ok, (k != 2));
      tick();
    end
    mem_data_ok = 1'b0;
    tick();

    // Response with empty FIFO
    mem_data_ok = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("err_no_inst_ok", inst_data_ok, 0);
    chk("err_no_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("err_set", protocol_err, 1);
    chk("err_no_pop", outstanding, 0);
    tick();

    // Reset mid-HOLD with two outstanding
    inst_req = 1'b1; inst_addr = 32'hBFC00020; mem_addr_ok = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    mem_addr_ok = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("rh_outstanding2", outstanding, 2);
    chk("rh_err_held", protocol_err, 1);
    tick();
    #1 reset = 1'b1;
    #1;
    chk("rh_async_outstanding", outstanding, 0);
    chk("rh_async_err", protocol_err, 0);
    chk("rh_async_mem_req", mem_req, 0);
    tick();
    reset = 1'b0; data_req = 1'b1; data_addr = 32'h1C000300;
    @(negedge clk);
    chk("rh_idle_rearb", mem_addr, 32'h1C000300);
    tick();
    inst_req = 1'b0; data_req = 1'b0;
    tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
